// File: rtl/axi_pwm_custom_ramp_ctrl.sv
// axi_pwm_custom_ramp_ctrl
//
// Fade sequencer for the 4-channel custom PWM LED interface. It owns the PWM
// period counter, flags the last cycle of each period, and steps a shared
// duty word through a ramp-up / hold / ramp-down profile. Duty words move
// only on period boundaries, so the PWM interface never sees a duty change
// in the middle of a period.
//
// Ports
//   pwm_clk          in   PWM clock, all state on the rising edge
//   rstn             in   async active-low reset
//   enable           in   level request to keep fading
//   step             in   duty delta per period (0 is treated as 1)
//   max_duty         in   ramp ceiling
//   hold_periods     in   periods spent at the ceiling
//   channel_mask     in   bit k selects whether channel k follows duty
//   end_of_period    out  high while period counter == PERIOD
//   data_channel_0-3 out  registered duty word per channel
//   busy             out  sequencer not idle
//   ramp_done        out  one-cycle pulse when ramp-down reaches zero
module axi_pwm_custom_ramp_ctrl #(
  parameter int PERIOD     = 4095,
  parameter int DATA_WIDTH = 12,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                  pwm_clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] max_duty,
  input  logic [HOLD_WIDTH-1:0] hold_periods,
  input  logic [3:0]            channel_mask,
  output logic                  end_of_period,
  output logic [DATA_WIDTH-1:0] data_channel_0,
  output logic [DATA_WIDTH-1:0] data_channel_1,
  output logic [DATA_WIDTH-1:0] data_channel_2,
  output logic [DATA_WIDTH-1:0] data_channel_3,
  output logic                  busy,
  output logic                  ramp_done
);

  localparam int NUM_CH = 4;
  localparam logic [DATA_WIDTH-1:0] PERIOD_W = DATA_WIDTH'(PERIOD);
  localparam logic [DATA_WIDTH-1:0] ONE_W    = DATA_WIDTH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;

  // Configuration snapshot; only refreshed when a new fade cycle starts.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] step;
    logic [DATA_WIDTH-1:0] max_duty;
    logic [HOLD_WIDTH-1:0] hold;
    logic [NUM_CH-1:0]     mask;
  } cfg_t;

  logic [DATA_WIDTH-1:0]             cnt_q, cnt_d;
  logic [1:0]                        state_q, state_d;
  logic [DATA_WIDTH-1:0]             duty_q, duty_d;
  logic [HOLD_WIDTH-1:0]             hold_q, hold_d;
  logic                              done_q, done_d;
  cfg_t                              cfg_q, cfg_d, cfg_live;
  logic [DATA_WIDTH:0]               sum;
  logic [NUM_CH-1:0]                 lane_en;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_q;

  // Period counter: starts at 0 after reset, so the first period is one cycle
  // longer; afterwards it wraps PERIOD -> 1.
  assign end_of_period = (cnt_q == PERIOD_W);
  assign cnt_d         = end_of_period ? ONE_W : cnt_q + ONE_W;

  always_comb begin
    cfg_live.step     = (step == '0) ? ONE_W : step;
    cfg_live.max_duty = max_duty;
    cfg_live.hold     = hold_periods;
    cfg_live.mask     = channel_mask;
  end

  // Extra carry bit so a ramp step near the top of the range cannot wrap.
  assign sum = {1'b0, duty_q} + {1'b0, cfg_q.step};

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    if (end_of_period) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = ST_UP;
            cfg_d   = cfg_live;
          end
        end
        ST_UP: begin
          if (!enable) begin
            state_d = ST_DOWN;
          end else if (duty_q == cfg_q.max_duty) begin
            state_d = ST_HOLD;
            hold_d  = cfg_q.hold;
          end else if (sum > {1'b0, cfg_q.max_duty}) begin
            duty_d = cfg_q.max_duty;
          end else begin
            duty_d = sum[DATA_WIDTH-1:0];
          end
        end
        ST_HOLD: begin
          if (!enable || hold_q == '0) state_d = ST_DOWN;
          else                         hold_d  = hold_q - 1'b1;
        end
        default: begin // ST_DOWN
          if (duty_q <= cfg_q.step) begin
            duty_d = '0;
            done_d = 1'b1;
            if (enable) begin
              state_d = ST_UP;
              cfg_d   = cfg_live;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            duty_d = duty_q - cfg_q.step;
          end
        end
      endcase
    end
  end

  // Lanes are fed from next-state values so the outputs carry no extra
  // latency relative to the duty register; idle blanks every lane.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      lane_en[k] = (state_d != ST_IDLE) && cfg_d.mask[k];
  end

  always_ff @(posedge pwm_clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      cfg_q   <= '0;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      cfg_q   <= cfg_d;
      for (int k = 0; k < NUM_CH; k++)
        data_q[k] <= lane_en[k] ? duty_d : '0;
    end
  end

  assign data_channel_0 = data_q[0];
  assign data_channel_1 = data_q[1];
  assign data_channel_2 = data_q[2];
  assign data_channel_3 = data_q[3];
  assign busy           = (state_q != ST_IDLE);
  assign ramp_done      = done_q;

endmodule

// File: tb/tb_axi_pwm_custom_ramp_ctrl.sv
// Directed bench for axi_pwm_custom_ramp_ctrl with a 15-cycle period.
module tb_axi_pwm_custom_ramp_ctrl;
  localparam int DW = 12;
  localparam int HW = 8;

  logic          pwm_clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic [DW-1:0] step, max_duty;
  logic [HW-1:0] hold_periods;
  logic [3:0]    channel_mask;
  logic          end_of_period, busy, ramp_done;
  logic [DW-1:0] data_channel_0, data_channel_1, data_channel_2, data_channel_3;

  int n_tests = 0;
  int n_fail  = 0;

  axi_pwm_custom_ramp_ctrl #(.PERIOD(15), .DATA_WIDTH(DW), .HOLD_WIDTH(HW)) dut (
    .pwm_clk(pwm_clk), .rstn(rstn), .enable(enable), .step(step),
    .max_duty(max_duty), .hold_periods(hold_periods), .channel_mask(channel_mask),
    .end_of_period(end_of_period), .data_channel_0(data_channel_0),
    .data_channel_1(data_channel_1), .data_channel_2(data_channel_2),
    .data_channel_3(data_channel_3), .busy(busy), .ramp_done(ramp_done)
  );

  always #5 pwm_clk = ~pwm_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles (negedges) until the next end_of_period; 0 if none within bound.
  task automatic eop_gap(output int gap);
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge pwm_clk);
      if (end_of_period === 1'b1) begin
        gap = i;
        break;
      end
    end
  endtask

  // Advance past the next EOP edge and land #1 after it.
  task automatic next_eop(input string tag);
    int g;
    eop_gap(g);
    chk({tag, "_eop_seen"}, 32'(g != 0), 32'd1);
    @(posedge pwm_clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ch0"}, 32'(data_channel_0), 32'd0);
    chk({tag, "_ch1"}, 32'(data_channel_1), 32'd0);
    chk({tag, "_ch2"}, 32'(data_channel_2), 32'd0);
    chk({tag, "_ch3"}, 32'(data_channel_3), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(ramp_done), 32'd0);
    chk({tag, "_eop"}, 32'(end_of_period), 32'd0);
  endtask

  // Walk one expected duty per EOP edge; drop enable after index drop_at,
  // expect the ramp_done pulse at index done_at. Two negedges later the
  // duty must be unchanged and the pulse gone.
  task automatic run_seq(input string tag, input int exp_q[$], input int drop_at,
                         input int done_at, input logic [3:0] m);
    for (int i = 0; i < exp_q.size(); i++) begin
      next_eop(tag);
      chk($sformatf("%s_ch0[%0d]", tag, i), 32'(data_channel_0), 32'(m[0] ? exp_q[i] : 0));
      chk($sformatf("%s_ch1[%0d]", tag, i), 32'(data_channel_1), 32'(m[1] ? exp_q[i] : 0));
      chk($sformatf("%s_ch2[%0d]", tag, i), 32'(data_channel_2), 32'(m[2] ? exp_q[i] : 0));
      chk($sformatf("%s_ch3[%0d]", tag, i), 32'(data_channel_3), 32'(m[3] ? exp_q[i] : 0));
      chk($sformatf("%s_done[%0d]", tag, i), 32'(ramp_done), 32'(i == done_at));
      if (i == drop_at) enable = 1'b0;
      @(negedge pwm_clk);
      @(negedge pwm_clk);
      chk($sformatf("%s_mid[%0d]", tag, i), 32'(data_channel_0), 32'(m[0] ? exp_q[i] : 0));
      chk($sformatf("%s_pulse[%0d]", tag, i), 32'(ramp_done), 32'd0);
    end
  endtask

  initial begin
    int q[$];
    int g;
    rstn = 1'b0; enable = 1'b0; step = '0; max_duty = '0;
    hold_periods = '0; channel_mask = '0;

    // Reset state and period timing
    #23;
    all_zero("reset");
    @(negedge pwm_clk);
    rstn = 1'b1;
    eop_gap(g);
    chk("first_gap", 32'(g), 32'd15);
    eop_gap(g);
    chk("second_gap", 32'(g), 32'd15);
    eop_gap(g);
    chk("third_gap", 32'(g), 32'd15);
    chk("idle_busy", 32'(busy), 32'd0);
    @(posedge pwm_clk);
    #1;

    // Full ramp: 0 on IDLE->UP, up to 64, HOLD for 2, DOWN on hold expiry
    step = 12'd16; max_duty = 12'd64; hold_periods = 8'd2; channel_mask = 4'hF;
    enable = 1'b1;
    q = '{0, 16, 32, 48, 64, 64, 64, 64, 64, 48, 32, 16, 0};
    run_seq("ramp", q, 8, 12, 4'hF);
    chk("ramp_end_busy", 32'(busy), 32'd0);

    // Saturation at the ceiling, no underflow on the way down
    step = 12'd40; max_duty = 12'd100; hold_periods = 8'd0; enable = 1'b1;
    q = '{0, 40, 80, 100, 100, 100, 60, 20, 0};
    run_seq("sat", q, 5, 8, 4'hF);
    chk("sat_end_busy", 32'(busy), 32'd0);

    // Mask and config shadowing: changes mid-ramp take effect on DOWN->UP
    step = 12'd16; max_duty = 12'd32; hold_periods = 8'd0; channel_mask = 4'b0101;
    enable = 1'b1;
    q = '{0, 16};
    run_seq("mask_a", q, -1, -1, 4'b0101);
    max_duty = 12'd200; channel_mask = 4'hF;
    q = '{32, 32, 32, 16, 0};
    run_seq("mask_b", q, -1, 4, 4'b0101);
    chk("relatch_busy", 32'(busy), 32'd1);
    // Abort from UP at 32: DOWN keeps 32, then 16, 0 and back to IDLE
    q = '{16, 32, 32, 16, 0};
    run_seq("abort", q, 1, 4, 4'hF);
    chk("abort_end_busy", 32'(busy), 32'd0);

    // max_duty = 0: straight to HOLD, ramp_done still pulses
    step = 12'd5; max_duty = 12'd0; hold_periods = 8'd1; enable = 1'b1;
    q = '{0, 0, 0, 0, 0};
    run_seq("max0", q, 3, 4, 4'hF);
    chk("max0_end_busy", 32'(busy), 32'd0);

    // step = 0 behaves as step = 1
    step = 12'd0; max_duty = 12'd3; hold_periods = 8'd0; enable = 1'b1;
    q = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
    run_seq("step0", q, 5, 8, 4'hF);

    // Async reset mid-UP at duty 48
    step = 12'd16; max_duty = 12'd64; hold_periods = 8'd2; enable = 1'b1;
    q = '{0, 16, 32, 48};
    run_seq("pre_rst", q, -1, -1, 4'hF);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    all_zero("midreset");
    enable = 1'b0;
    @(negedge pwm_clk);
    rstn = 1'b1;
    eop_gap(g);
    chk("post_rst_gap", 32'(g), 32'd15);
    chk("post_rst_ch0", 32'(data_channel_0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
